// File: rtl/instruction_fetch.sv
// Instruction fetch front end: loadable imem, PC sequencing under stall, and a registered IF/ID word.
// Optional macro INSTR_COUNT_EN adds a saturating count of instructions accepted by the decoder.
//   state  | meaning
//   IDLE   | after reset; imem loadable, waiting for start
//   RUN    | fetching one word per unstalled cycle
//   DONE   | stopped on HALT or end of memory; loadable, restartable
module instruction_fetch #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W       = 5,
  parameter int INST_W     = 16
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              start,
  input  logic              stall,
  output logic [2:0]        inst,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [6:0]        imm,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [INST_W-1:0] imem [IMEM_DEPTH];

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      inst_q, inst_d, rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [6:0]      imm_q, imm_d;
  logic            valid_q, valid_d;
  logic            end_q, end_d;

  logic [INST_W-1:0] word;
  logic              is_halt;
  logic              at_end;
  logic              can_load;
  logic              start_ok;

  assign word     = imem[pc_q];
  assign is_halt  = (word[15:13] == 3'd1) || (word[15:13] == 3'd2) || (word[15:13] == 3'd3);
  assign at_end   = (pc_q == PC_W'(IMEM_DEPTH - 1));
  assign can_load = (state_q != S_RUN);
  assign start_ok = can_load && start;

  always_ff @(posedge sysclk) begin
    if (can_load && load_en) imem[load_addr] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    end_d   = end_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          end_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          // The last word of memory stays presented until the decoder accepts it.
          if (end_q || is_halt) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            inst_d  = word[15:13];
            rd_d    = word[12:10];
            rs_d    = word[9:7];
            rt_d    = word[6:4];
            imm_d   = word[6:0];
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            end_d   = at_end;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
      end_q   <= end_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (start_ok) begin
      count_q <= '0;
    end else if (valid_q && !stall && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign instr_count = count_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign inst       = inst_q;
  assign rd         = rd_q;
  assign rs         = rs_q;
  assign rt         = rt_q;
  assign imm        = imm_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign busy       = (state_q == S_RUN);
  assign halted     = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed program scenarios plus randomized programs and stalls
// scored against the instruction stream a program should produce.
module tb_instruction_fetch;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  inst, rd, rs, rt;
  logic [6:0]  imm;
  logic        inst_valid;
  logic [4:0]  pc;
  logic        busy, halted;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] mem [32];

  instruction_fetch dut (
    .sysclk(sysclk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall),
    .inst(inst), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .inst_valid(inst_valid),
    .pc(pc), .busy(busy), .halted(halted)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] fld(input logic [15:0] w);
    return {w[15:13], w[12:10], w[9:7], w[6:4], w[6:0]};
  endfunction

  function automatic logic [18:0] dut_f();
    return {inst, rd, rs, rt, imm};
  endfunction

  function automatic bit op_halts(input logic [15:0] w);
    return (w[15:13] >= 3'd1) && (w[15:13] <= 3'd3);
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    mem[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef INSTR_COUNT_EN
    check_val(tag, 32'(instr_count), 32'(exp));
`endif
  endtask

  task automatic run_random(input int iter);
    logic [15:0] exp_q[$];
    logic [15:0] w;
    logic [2:0]  ops[5];
    logic [18:0] snap_f;
    logic [5:0]  snap_vp;
    int          addr, final_pc, idx, unstalled, cycles;
    bit          s, no_halt;
    ops[0] = 3'd0; ops[1] = 3'd4; ops[2] = 3'd5; ops[3] = 3'd6; ops[4] = 3'd7;
    no_halt = (iter % 2 == 0);
    for (int a = 0; a < 32; a++) begin
      w = 16'($urandom);
      if (!no_halt && $urandom_range(0, 9) == 0) w[15:13] = 3'($urandom_range(1, 3));
      else w[15:13] = ops[$urandom_range(0, 4)];
      load_word(5'(a), w);
    end
    if ($urandom_range(0, 1) == 1) begin
      w = {ops[$urandom_range(0, 4)], 13'($urandom)};
      load_en = 1'b1; load_addr = 5'd0; load_data = w;
      mem[0] = w;
    end
    pulse_start();
    load_en = 1'b0;
    addr = 0;
    while (addr < 32 && !op_halts(mem[addr])) begin
      exp_q.push_back(mem[addr]);
      addr++;
    end
    final_pc = (addr < 32) ? addr : 0;
    check_val("rnd_start_busy", 32'(busy), 32'd1);
    check_val("rnd_start_pc", 32'(pc), 32'd0);
    check_count("rnd_start_count", 0);
    idx = 0; unstalled = 0; cycles = 0;
    while (cycles < 400 && !halted) begin
      s = ($urandom_range(0, 9) < 3);
      stall = s;
      load_en = ($urandom_range(0, 7) == 0);
      load_addr = 5'($urandom);
      load_data = 16'($urandom);
      if (inst_valid && !s) begin
        if (idx < exp_q.size()) check_val("rnd_fields", 32'(dut_f()), 32'(fld(exp_q[idx])));
        else check_val("rnd_extra_inst", 32'(idx), 32'(exp_q.size()));
        check_val("rnd_pc", 32'(pc), 32'((idx + 1) % 32));
        idx++;
      end
      if (!s) unstalled++;
      snap_f  = dut_f();
      snap_vp = {inst_valid, pc};
      tick();
      cycles++;
      if (s) begin
        check_val("rnd_hold_fields", 32'(dut_f()), 32'(snap_f));
        check_val("rnd_hold_vp", 32'({inst_valid, pc}), 32'(snap_vp));
      end
    end
    stall = 1'b0; load_en = 1'b0;
    check_val("rnd_halted", 32'(halted), 32'd1);
    check_val("rnd_consumed", 32'(idx), 32'(exp_q.size()));
    check_val("rnd_unstalled_edges", 32'(unstalled), 32'(exp_q.size() + 1));
    check_val("rnd_final_pc", 32'(pc), 32'(final_pc));
    check_val("rnd_final_valid", 32'(inst_valid), 32'd0);
    check_val("rnd_final_busy", 32'(busy), 32'd0);
    check_count("rnd_final_count", exp_q.size());
  endtask

  initial begin
    #2;
    check_val("rst_fields", 32'(dut_f()), 32'd0);
    check_val("rst_valid", 32'(inst_valid), 32'd0);
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_count("rst_count", 0);
    #1 rst = 1'b0;

    // Basic three-word program
    load_word(5'd0, 16'h8405);
    load_word(5'd1, 16'hC883);
    load_word(5'd2, 16'h2000);
    pulse_start();
    check_val("p1_start_busy", 32'(busy), 32'd1);
    check_val("p1_start_pc", 32'(pc), 32'd0);
    check_val("p1_start_valid", 32'(inst_valid), 32'd0);
    tick();
    check_val("p1_i0_fields", 32'(dut_f()), 32'({3'd4, 3'd1, 3'd0, 3'd0, 7'd5}));
    check_val("p1_i0_valid", 32'(inst_valid), 32'd1);
    check_val("p1_i0_pc", 32'(pc), 32'd1);
    tick();
    check_val("p1_i1_fields", 32'(dut_f()), 32'({3'd6, 3'd2, 3'd1, 3'd0, 7'd3}));
    check_val("p1_i1_pc", 32'(pc), 32'd2);
    tick();
    check_val("p1_done_valid", 32'(inst_valid), 32'd0);
    check_val("p1_done_halted", 32'(halted), 32'd1);
    check_val("p1_done_pc", 32'(pc), 32'd2);
    check_val("p1_done_fields_hold", 32'(dut_f()), 32'({3'd6, 3'd2, 3'd1, 3'd0, 7'd3}));
    check_count("p1_done_count", 2);

    // Stall for three cycles with an ignored load into addr 1
    pulse_start();
    check_count("p2_restart_count", 0);
    tick();
    check_val("p2_i0_fields", 32'(dut_f()), 32'(fld(16'h8405)));
    stall = 1'b1; load_en = 1'b1; load_addr = 5'd1; load_data = 16'hA000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("p2_stall_inst", 32'(inst), 32'd4);
      check_val("p2_stall_pc", 32'(pc), 32'd1);
      check_val("p2_stall_valid", 32'(inst_valid), 32'd1);
    end
    stall = 1'b0; load_en = 1'b0;
    tick();
    check_val("p2_i1_fields", 32'(dut_f()), 32'(fld(16'hC883)));
    tick();
    check_val("p2_done_halted", 32'(halted), 32'd1);
    check_count("p2_done_count", 2);

    // Asynchronous reset mid-run, then replay
    pulse_start();
    tick();
    check_val("p3_pre_pc", 32'(pc), 32'd1);
    rst = 1'b1;
    #2;
    check_val("p3_rst_fields", 32'(dut_f()), 32'd0);
    check_val("p3_rst_valid", 32'(inst_valid), 32'd0);
    check_val("p3_rst_pc", 32'(pc), 32'd0);
    check_val("p3_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    pulse_start();
    tick();
    check_val("p3_replay_fields", 32'(dut_f()), 32'(fld(16'h8405)));
    tick(); tick();
    check_val("p3_done_halted", 32'(halted), 32'd1);

    // Full memory of ADDs runs to the end and stops
    for (int a = 0; a < 32; a++) load_word(5'(a), 16'h0000);
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      tick();
      check_val("p4_valid", 32'(inst_valid), 32'd1);
      check_val("p4_pc", 32'(pc), 32'((i + 1) % 32));
      check_val("p4_fields", 32'(dut_f()), 32'd0);
    end
    tick();
    check_val("p4_done_valid", 32'(inst_valid), 32'd0);
    check_val("p4_done_halted", 32'(halted), 32'd1);
    check_val("p4_done_pc", 32'(pc), 32'd0);
    check_count("p4_done_count", 32);

    for (int it = 0; it < 8; it++) run_random(it);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
